// File: rtl/wave_gen_pkg.sv
// rtl/wave_gen_pkg.sv - shared state type and constants for the waveform ROM reader
package wave_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} wave_state_t;

  localparam int         DEF_ADDR_WIDTH  = 10;
  localparam int         DEF_PHASE_WIDTH = 32;
  localparam logic [7:0] DAC_MIDSCALE    = 8'h80;
  localparam logic [8:0] AMP_UNITY       = 9'd256;
endpackage

// File: rtl/wave_amp_scale.sv
// rtl/wave_amp_scale.sv - combinational gain about midscale with saturation to the DAC range
module wave_amp_scale
  import wave_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] MIDSCALE   = DAC_MIDSCALE
) (
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [8:0]            amp,
  output logic [DATA_WIDTH-1:0] scaled
);
  localparam int PW = DATA_WIDTH + 10;
  localparam logic signed [PW-1:0] MAX_CODE = PW'((1 << DATA_WIDTH) - 1);
  localparam logic signed [PW-1:0] MID_EXT  = PW'(MIDSCALE);

  logic signed [DATA_WIDTH:0] centered;
  logic        [9:0]          gain;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       level;

  always_comb begin
    centered = $signed({1'b0, sample}) - $signed({1'b0, MIDSCALE});
    gain     = (amp > AMP_UNITY) ? {1'b0, AMP_UNITY} : {1'b0, amp};
    prod     = PW'(centered) * $signed(PW'(gain));
    // Arithmetic shift floors toward minus infinity, keeping negative swings symmetric-biased low
    level    = (prod >>> 8) + MID_EXT;
    if (level[PW-1])
      scaled = '0;
    else if (level > MAX_CODE)
      scaled = '1;
    else
      scaled = level[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/wave_rom_reader.sv
// rtl/wave_rom_reader.sv - DDS phase accumulator driving a waveform ROM and the AD9708 DAC bus
module wave_rom_reader
  import wave_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int                    ROM_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] MIDSCALE    = DAC_MIDSCALE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic                   ftw_load,
  input  logic [ADDR_WIDTH-1:0]  phase_ofs,
  input  logic [8:0]             amp,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic                   rom_clk_en,
  input  logic [DATA_WIDTH-1:0]  rom_rd_data,
  output logic [DATA_WIDTH-1:0]  dac_data,
  output logic                   dac_valid,
  output logic                   busy,
  output logic                   period_tick
);
  localparam logic [1:0] LAT_LAST = 2'(ROM_LATENCY);

  wave_state_t            state, state_n;
  logic [PHASE_WIDTH-1:0] phase, phase_n, inc;
  logic [ADDR_WIDTH-1:0]  ofs, ofs_n, addr_n;
  logic                   issue, issue_n, wrap, wrap_n, flushing, flush_n;
  logic [1:0]             cnt, cnt_n;
  logic [PHASE_WIDTH:0]   sum;
  logic [ADDR_WIDTH-1:0]  sum_addr;
  logic [ROM_LATENCY-1:0] v_pipe, t_pipe;
  logic [DATA_WIDTH-1:0]  scaled;

  assign sum        = {1'b0, phase} + {1'b0, inc};
  assign sum_addr   = sum[PHASE_WIDTH-1 -: ADDR_WIDTH] + ofs;
  assign busy       = (state != IDLE);
  assign rom_clk_en = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      inc      <= '0;
      ofs      <= '0;
      rom_addr <= '0;
      issue    <= 1'b0;
      wrap     <= 1'b0;
      flushing <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      ofs      <= ofs_n;
      rom_addr <= addr_n;
      issue    <= issue_n;
      wrap     <= wrap_n;
      flushing <= flush_n;
      cnt      <= cnt_n;
      if (ftw_load)
        inc <= ftw;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    ofs_n   = ofs;
    addr_n  = rom_addr;
    issue_n = 1'b0;
    wrap_n  = 1'b0;
    flush_n = flushing;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          phase_n = '0;
          ofs_n   = phase_ofs;
          addr_n  = phase_ofs;
          issue_n = 1'b1;
          wrap_n  = 1'b1;
          flush_n = 1'b0;
          cnt_n   = '0;
        end
      end
      RUN: begin
        phase_n = sum[PHASE_WIDTH-1:0];
        addr_n  = sum_addr;
        issue_n = 1'b1;
        wrap_n  = sum[PHASE_WIDTH];
        if (stop)
          state_n = DRAIN;
      end
      DRAIN: begin
        // The wrapped address is never issued; only in-flight reads are allowed to land
        if (!flushing) begin
          if (sum[PHASE_WIDTH]) begin
            flush_n = 1'b1;
            cnt_n   = '0;
          end else begin
            phase_n = sum[PHASE_WIDTH-1:0];
            addr_n  = sum_addr;
            issue_n = 1'b1;
          end
        end else if (cnt == LAT_LAST) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  wave_amp_scale #(
    .DATA_WIDTH(DATA_WIDTH),
    .MIDSCALE  (MIDSCALE)
  ) u_scale (
    .sample(rom_rd_data),
    .amp   (amp),
    .scaled(scaled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe      <= '0;
      t_pipe      <= '0;
      dac_data    <= MIDSCALE;
      dac_valid   <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      v_pipe[0] <= issue;
      t_pipe[0] <= issue & wrap;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        t_pipe[i] <= t_pipe[i-1];
      end
      dac_valid   <= v_pipe[ROM_LATENCY-1];
      period_tick <= t_pipe[ROM_LATENCY-1];
      dac_data    <= v_pipe[ROM_LATENCY-1] ? scaled : MIDSCALE;
    end
  end
endmodule
